// File: rtl/reg_write_arbiter.sv
// rtl/reg_write_arbiter.sv - round-robin arbiter sharing one register-file write port
// Define ARB_STATS_EN to add per-requester saturating grant counters (STAT_SEL/STAT_CNT).
module reg_write_arbiter #(
  parameter int NREQ = 4,
  parameter int AW   = 4,
  parameter int DW   = 32
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [NREQ-1:0]    REQ_VALID,
  output logic [NREQ-1:0]    REQ_READY,
  input  logic [NREQ*AW-1:0] REQ_ADDR,
  input  logic [NREQ*DW-1:0] REQ_DATA,
  input  logic               WR_STALL,
  output logic               WR_EN,
  output logic [AW-1:0]      WR_ADDR,
  output logic [DW-1:0]      WR_DATA,
  output logic               BUSY
`ifdef ARB_STATS_EN
  ,
  input  logic [2:0]         STAT_SEL,
  output logic [15:0]        STAT_CNT
`endif
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0]   ptr_q, ptr_d;
  logic            wr_en_q, wr_en_d;
  logic [AW-1:0]   wr_addr_q, wr_addr_d;
  logic [DW-1:0]   wr_data_q, wr_data_d;

  logic            found_hi, found_lo, found;
  logic [PW-1:0]   win_hi, win_lo, winner;
  logic [NREQ-1:0] grant;
  logic            xfer;

  // Two-pass search: lowest valid index at or above the pointer wins, else lowest index overall.
  always_comb begin
    found_hi = 1'b0;
    found_lo = 1'b0;
    win_hi   = '0;
    win_lo   = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (REQ_VALID[i]) begin
        if (i >= int'(ptr_q)) begin
          found_hi = 1'b1;
          win_hi   = PW'(i);
        end else begin
          found_lo = 1'b1;
          win_lo   = PW'(i);
        end
      end
    end
    found  = found_hi | found_lo;
    winner = found_hi ? win_hi : win_lo;
  end

  always_comb begin
    grant = '0;
    if (!RST && !WR_STALL && found) begin
      grant[winner] = 1'b1;
    end
    xfer = |grant;
  end

  always_comb begin
    wr_en_d   = xfer;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    ptr_d     = ptr_q;
    if (xfer) begin
      wr_addr_d = REQ_ADDR[winner*AW +: AW];
      wr_data_d = REQ_DATA[winner*DW +: DW];
      if (int'(winner) == NREQ - 1) begin
        ptr_d = '0;
      end else begin
        ptr_d = winner + PW'(1);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      ptr_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      ptr_q     <= ptr_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign REQ_READY = grant;
  assign BUSY      = |(REQ_VALID & ~grant);
  assign WR_EN     = wr_en_q;
  assign WR_ADDR   = wr_addr_q;
  assign WR_DATA   = wr_data_q;

`ifdef ARB_STATS_EN
  logic [15:0] cnt_q [NREQ];
  logic [15:0] cnt_d [NREQ];

  // Counters stick at all-ones instead of wrapping.
  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      cnt_d[i] = cnt_q[i];
    end
    if (xfer && cnt_q[winner] != 16'hFFFF) begin
      cnt_d[winner] = cnt_q[winner] + 16'd1;
    end
  end

  always_ff @(posedge CLK) begin
    for (int i = 0; i < NREQ; i++) begin
      if (RST) begin
        cnt_q[i] <= '0;
      end else begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  always_comb begin
    STAT_CNT = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (STAT_SEL == 3'(i)) begin
        STAT_CNT = cnt_q[i];
      end
    end
  end
`endif

endmodule

// File: tb/tb_reg_write_arbiter.sv
// tb/tb_reg_write_arbiter.sv - scoreboard bench for reg_write_arbiter
// Directed scenarios followed by randomized traffic against a queue-based reference model.
module tb_reg_write_arbiter;

  localparam int NREQ = 4;
  localparam int AW   = 4;
  localparam int DW   = 32;

  bit                 CLK = 1'b0;
  logic               RST;
  logic [NREQ-1:0]    REQ_VALID;
  logic [NREQ-1:0]    REQ_READY;
  logic [NREQ*AW-1:0] REQ_ADDR;
  logic [NREQ*DW-1:0] REQ_DATA;
  logic               WR_STALL;
  logic               WR_EN;
  logic [AW-1:0]      WR_ADDR;
  logic [DW-1:0]      WR_DATA;
  logic               BUSY;
`ifdef ARB_STATS_EN
  logic [2:0]         STAT_SEL;
  logic [15:0]        STAT_CNT;
`endif

  reg_write_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
    .CLK(CLK),
    .RST(RST),
    .REQ_VALID(REQ_VALID),
    .REQ_READY(REQ_READY),
    .REQ_ADDR(REQ_ADDR),
    .REQ_DATA(REQ_DATA),
    .WR_STALL(WR_STALL),
    .WR_EN(WR_EN),
    .WR_ADDR(WR_ADDR),
    .WR_DATA(WR_DATA),
    .BUSY(BUSY)
`ifdef ARB_STATS_EN
    ,
    .STAT_SEL(STAT_SEL),
    .STAT_CNT(STAT_CNT)
`endif
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [NREQ-1:0] ready;
    logic            busy;
    logic            en;
    logic [AW-1:0]   addr;
    logic [DW-1:0]   data;
    logic [15:0]     stat;
    bit              chk_wr;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;
  bit   mon_en = 1'b0;

  // Requester-side state: each requester holds its write until it is accepted.
  bit            rv [NREQ];
  logic [AW-1:0] ra [NREQ];
  logic [DW-1:0] rd [NREQ];

  // Reference model state.
  int            m_ptr = 0;
  bit            m_en = 1'b0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_data = '0;
  bit            m_init = 1'b0;
  int            m_cnt [NREQ];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic do_cycle(input bit rst, input bit stall, input bit refill);
    exp_t            e;
    int              w;
    int              idx;
    logic [NREQ-1:0] rdy;
    logic [NREQ-1:0] vmask;
    @(posedge CLK);
    #1;
    RST      = rst;
    WR_STALL = stall;
    for (int i = 0; i < NREQ; i++) begin
      REQ_VALID[i]            = rv[i];
      REQ_ADDR[i*AW +: AW]    = ra[i];
      REQ_DATA[i*DW +: DW]    = rd[i];
      vmask[i]                = rv[i];
    end
`ifdef ARB_STATS_EN
    STAT_SEL = 3'($urandom_range(0, 7));
    e.stat   = (int'(STAT_SEL) < NREQ) ? 16'(m_cnt[STAT_SEL]) : 16'd0;
`else
    e.stat   = '0;
`endif
    w = -1;
    if (!rst && !stall) begin
      for (int k = 0; k < NREQ; k++) begin
        idx = (m_ptr + k) % NREQ;
        if (w < 0 && rv[idx]) w = idx;
      end
    end
    rdy = '0;
    if (w >= 0) rdy[w] = 1'b1;
    e.ready  = rdy;
    e.busy   = |(vmask & ~rdy);
    e.en     = m_en;
    e.addr   = m_addr;
    e.data   = m_data;
    e.chk_wr = m_init;
    exp_q.push_back(e);
    mon_en = 1'b1;
    if (rst) begin
      m_en   = 1'b0;
      m_addr = '0;
      m_data = '0;
      m_ptr  = 0;
      m_init = 1'b1;
      for (int i = 0; i < NREQ; i++) m_cnt[i] = 0;
    end else if (w >= 0) begin
      m_en   = 1'b1;
      m_addr = ra[w];
      m_data = rd[w];
      m_ptr  = (w + 1) % NREQ;
      if (m_cnt[w] < 65535) m_cnt[w]++;
      if (!refill) rv[w] = 1'b0;
    end else begin
      m_en = 1'b0;
    end
  endtask

  always @(negedge CLK) begin
    exp_t e;
    if (mon_en) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL scoreboard_empty: got 0 entries expected 1 at %0t", $time);
      end else begin
        e = exp_q.pop_front();
        check("req_ready", 32'(REQ_READY), 32'(e.ready));
        check("busy", 32'(BUSY), 32'(e.busy));
        if (e.chk_wr) begin
          check("wr_en", 32'(WR_EN), 32'(e.en));
          check("wr_addr", 32'(WR_ADDR), 32'(e.addr));
          check("wr_data", WR_DATA, e.data);
`ifdef ARB_STATS_EN
          check("stat_cnt", 32'(STAT_CNT), 32'(e.stat));
`endif
        end
      end
    end
  end

  initial begin
    RST       = 1'b1;
    WR_STALL  = 1'b0;
    REQ_VALID = '0;
    REQ_ADDR  = '0;
    REQ_DATA  = '0;
`ifdef ARB_STATS_EN
    STAT_SEL  = '0;
`endif
    for (int i = 0; i < NREQ; i++) begin
      rv[i] = 1'b0;
      ra[i] = '0;
      rd[i] = '0;
      m_cnt[i] = 0;
    end

    // Reset held two cycles.
    do_cycle(1'b1, 1'b0, 1'b0);
    do_cycle(1'b1, 1'b0, 1'b0);

    // Lone requester 2 with addr 5 / data 100.
    rv[2] = 1'b1; ra[2] = 4'd5; rd[2] = 32'd100;
    do_cycle(1'b0, 1'b0, 1'b0);
    do_cycle(1'b0, 1'b0, 1'b0);

    // Re-reset, then all four valid constantly: grants 0,1,2,3,0.
    do_cycle(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < NREQ; i++) begin
      rv[i] = 1'b1;
      ra[i] = AW'(i);
      rd[i] = 32'd1234 + 32'(i);
    end
    for (int n = 0; n < 5; n++) do_cycle(1'b0, 1'b0, 1'b1);

    // Grant to req 1, stall three cycles, then req 2.
    do_cycle(1'b0, 1'b0, 1'b1);
    for (int n = 0; n < 3; n++) do_cycle(1'b0, 1'b1, 1'b1);
    do_cycle(1'b0, 1'b0, 1'b1);

    // Grants 3,0,1,2 then reset mid-stream; req 0 first afterwards.
    for (int n = 0; n < 4; n++) do_cycle(1'b0, 1'b0, 1'b1);
    do_cycle(1'b1, 1'b0, 1'b1);
    do_cycle(1'b0, 1'b0, 1'b1);
    do_cycle(1'b0, 1'b0, 1'b1);

    // Randomized traffic, stalls and occasional resets.
    for (int i = 0; i < NREQ; i++) rv[i] = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!rv[i] && ($urandom % 3 == 0)) begin
          rv[i] = 1'b1;
          ra[i] = AW'($urandom);
          rd[i] = $urandom;
        end
      end
      do_cycle(($urandom % 50) == 0, ($urandom % 5) == 0, 1'b0);
    end

    @(negedge CLK);
    #1;
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
